// File: rtl/sat_accum_16bit.sv
// Saturating 16-bit accumulator: folds a counted stream of signed operands into
// a running sum (add or subtract mode) with signed clamping and a sticky flag.
module sat_accum_16bit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             sub,
  input  logic             in_vld,
  input  logic [15:0]      in_data,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [15:0]      acc_out,
  output logic             sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             sub_mode;
  logic             sat_r;
  logic             in_rdy_r;
  logic             out_vld_r;
  logic             busy_r;

  logic [16:0]      sum;
  logic [15:0]      clamped;
  logic             clip;

  // 17-bit sign-extended arithmetic is exact for every operand pair, including
  // 0 - 0x8000, so overflow is simply bit 16 disagreeing with bit 15.
  always_comb begin
    if (sub_mode) begin
      sum = {acc[15], acc} - {in_data[15], in_data};
    end else begin
      sum = {acc[15], acc} + {in_data[15], in_data};
    end
    clip    = 1'b0;
    clamped = sum[15:0];
    if (sum[16] != sum[15]) begin
      clip    = 1'b1;
      clamped = sum[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sub_mode  <= 1'b0;
      sat_r     <= 1'b0;
      in_rdy_r  <= 1'b0;
      out_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            sat_r    <= 1'b0;
            sub_mode <= sub;
            busy_r   <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              state    <= ACCUM;
              in_rdy_r <= 1'b1;
            end else begin
              state     <= DONE;
              out_vld_r <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_vld && in_rdy_r) begin
            acc <= clamped;
            if (clip) begin
              sat_r <= 1'b1;
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state     <= DONE;
              in_rdy_r  <= 1'b0;
              out_vld_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_rdy) begin
            state     <= IDLE;
            out_vld_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_rdy_r  <= 1'b0;
          out_vld_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy  = in_rdy_r;
  assign out_vld = out_vld_r;
  assign busy    = busy_r;
  assign acc_out = acc;
  assign sat     = sat_r;

endmodule

// File: tb/tb_sat_accum_16bit.sv
// Self-checking bench for sat_accum_16bit: directed vector table, randomized
// runs against an integer reference model, and handshake/reset corner sequences.
module tb_sat_accum_16bit;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             sub;
  logic             in_vld;
  logic [15:0]      in_data;
  logic             in_rdy;
  logic             out_vld;
  logic             out_rdy;
  logic [15:0]      acc_out;
  logic             sat;
  logic             busy;

  sat_accum_16bit #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .sub     (sub),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .acc_out (acc_out),
    .sat     (sat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] opbuf [16];

  typedef struct {
    int          n;
    bit          s;
    logic [15:0] op0, op1, op2, op3;
    logic [15:0] exp_acc;
    bit          exp_sat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: exact integer arithmetic with clamping to the int16 range.
  task automatic model(input int n, input bit s, output logic [15:0] a, output bit st);
    int acc;
    int v;
    logic signed [15:0] t;
    acc = 0;
    st  = 1'b0;
    for (int i = 0; i < n; i++) begin
      t   = opbuf[i];
      v   = t;
      acc = s ? acc - v : acc + v;
      if (acc > 32767)  begin acc = 32767;  st = 1'b1; end
      if (acc < -32768) begin acc = -32768; st = 1'b1; end
    end
    a = acc[15:0];
  endtask

  // Runs one accumulation; when gaps is set, in_vld drops randomly between operands.
  task automatic do_run(input int n, input bit s, input bit gaps,
                        output logic [15:0] res_acc, output logic res_sat);
    logic [15:0] ma;
    bit          ms;
    @(negedge clk);
    start = 1'b1; len = CNT_W'(n); sub = s;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(3) == 0) begin
        in_vld = 1'b0;
        in_data = 16'($urandom);
        @(negedge clk);
      end
      check("in_rdy_accum", in_rdy, 1);
      in_vld = 1'b1; in_data = opbuf[i];
      @(negedge clk);
      model(i + 1, s, ma, ms);
      check("acc_step", acc_out, ma);
    end
    in_vld = 1'b0;
    check("out_vld_done", out_vld, 1);
    check("in_rdy_done", in_rdy, 0);
    res_acc = acc_out;
    res_sat = sat;
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, ma;
    logic        rs;
    bit          ms;
    int          n;
    bit          s;
    int          pat [7];
    int          k;

    vecs[0] = '{3, 1'b0, 16'd15,   16'd4,    16'hFFF8, 16'd0, 16'h000B, 1'b0};
    vecs[1] = '{2, 1'b0, 16'h7FFF, 16'h7FFF, 16'd0,    16'd0, 16'h7FFF, 1'b1};
    vecs[2] = '{2, 1'b0, 16'h8001, 16'h8001, 16'd0,    16'd0, 16'h8000, 1'b1};
    vecs[3] = '{2, 1'b1, 16'h8000, 16'h7FFF, 16'd0,    16'd0, 16'h0000, 1'b1};
    vecs[4] = '{0, 1'b0, 16'd0,    16'd0,    16'd0,    16'd0, 16'h0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0;
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acc", acc_out, 0);
    check("rst_sat", sat, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      opbuf[0] = vecs[v].op0; opbuf[1] = vecs[v].op1;
      opbuf[2] = vecs[v].op2; opbuf[3] = vecs[v].op3;
      do_run(vecs[v].n, vecs[v].s, 1'b0, ra, rs);
      check("vec_acc", ra, vecs[v].exp_acc);
      check("vec_sat", rs, vecs[v].exp_sat);
    end

    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 12);
      s = $urandom_range(1);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3))
          0: opbuf[i] = 16'h8000;
          1: opbuf[i] = 16'h7FFF;
          default: opbuf[i] = 16'($urandom);
        endcase
      end
      do_run(n, s, r[0], ra, rs);
      model(n, s, ma, ms);
      check("rnd_acc", ra, ma);
      check("rnd_sat", rs, ms);
    end

    // len=0: DONE the cycle after start, no operand consumed.
    @(negedge clk);
    start = 1'b1; len = '0; in_vld = 1'b1; in_data = 16'd99;
    @(negedge clk);
    start = 1'b0;
    check("len0_out_vld", out_vld, 1);
    check("len0_in_rdy", in_rdy, 0);
    check("len0_acc", acc_out, 0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0; in_vld = 1'b0;
    check("len0_idle", busy, 0);

    // Backpressure: in_vld pattern 1,0,0,1,1,0,1 carrying operands 1..4.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    @(negedge clk);
    start = 1'b1; len = 8'd4; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    for (int i = 0; i < 7; i++) begin
      in_vld  = pat[i][0];
      in_data = pat[i] != 0 ? 16'(k) : 16'd50;
      if (pat[i] != 0) k++;
      @(negedge clk);
    end
    in_vld = 1'b0;
    check("bp_acc", acc_out, 10);
    check("bp_out_vld", out_vld, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd2;
      @(negedge clk);
      check("bp_hold_vld", out_vld, 1);
      check("bp_hold_acc", acc_out, 10);
    end
    start = 1'b0;
    check("bp_busy_done", busy, 1);
    check("bp_in_rdy_done", in_rdy, 0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_vld", out_vld, 0);
    check("bp_idle_acc", acc_out, 10);

    // Reset mid-run after two saturating transfers.
    @(negedge clk);
    start = 1'b1; len = 8'd5; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_vld = 1'b1; in_data = 16'h7FFF;
    repeat (2) @(negedge clk);
    check("mid_sat_set", sat, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_acc", acc_out, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_rdy", in_rdy, 0);
    rst_n = 1'b1; in_vld = 1'b0;
    opbuf[0] = 16'd7;
    do_run(1, 1'b0, 1'b0, ra, rs);
    check("post_rst_acc", ra, 7);
    check("post_rst_sat", rs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
